br_issue_queue: RTL and testbench

In-order issue queue for branch/jump micro-ops, sitting directly upstream of the branch functional unit. Accepts renamed branch ops from dispatch and captures source operands from the common data bus (CDB) while they wait. Issues the oldest entry once both operands are ready, through a registered output stage that drives the branch unit's issue inputs. Branches leave strictly in program order.

---
 rtl/br_issue_queue.sv | 207 ++++++++++++++++++++
 tb/tb_br_issue_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_issue_queue.sv
// br_issue_queue: in-order issue queue for branch micro-ops with CDB operand capture.
// Define BR_IQ_CDB_BYPASS_EN to let a CDB broadcast satisfy the head entry in the same cycle.
module br_issue_queue #(
  parameter int unsigned BR_IQ_DEPTH      = 4,
  parameter int unsigned DATA_WIDTH_BR_OP = 4,
  parameter int unsigned PC_WIDTH         = 32,
  parameter int unsigned WORD_WIDTH       = 32,
  parameter int unsigned ROB_DEPTH        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           br_dispatch_en,
  input  logic [DATA_WIDTH_BR_OP-1:0]    br_dispatch_op,
  input  logic [PC_WIDTH-1:0]            br_dispatch_pc,
  input  logic [WORD_WIDTH-1:0]          br_dispatch_imm,
  input  logic [$clog2(ROB_DEPTH)-1:0]   br_dispatch_rs1_rob,
  input  logic [$clog2(ROB_DEPTH)-1:0]   br_dispatch_rs2_rob,
  input  logic                           br_dispatch_rs1_ready,
  input  logic                           br_dispatch_rs2_ready,
  input  logic [WORD_WIDTH-1:0]          br_dispatch_rs1_value,
  input  logic [WORD_WIDTH-1:0]          br_dispatch_rs2_value,
  input  logic [$clog2(ROB_DEPTH)-1:0]   br_dispatch_Pdst,
  input  logic                           cdb_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0]   cdb_rob,
  input  logic [WORD_WIDTH-1:0]          cdb_value,
  input  logic                           br_flush,
  output logic                           br_iq_full,
  output logic [$clog2(BR_IQ_DEPTH):0]   br_iq_count,
  output logic                           br_issue_en,
  output logic [DATA_WIDTH_BR_OP-1:0]    br_issue_queue_op,
  output logic [PC_WIDTH-1:0]            br_issue_queue_pc,
  output logic [WORD_WIDTH-1:0]          br_issue_queue_imm,
  output logic [WORD_WIDTH-1:0]          br_issue_queue_rs1_value,
  output logic [WORD_WIDTH-1:0]          br_issue_queue_rs2_value,
  output logic [$clog2(ROB_DEPTH)-1:0]   br_issue_queue_Pdst_out
);

  localparam int unsigned PTR_W = $clog2(BR_IQ_DEPTH);
  localparam int unsigned TAG_W = $clog2(ROB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]      rob;
    logic                  ready;
    logic [WORD_WIDTH-1:0] value;
  } opnd_t;

  typedef struct packed {
    logic                        valid;
    logic [DATA_WIDTH_BR_OP-1:0] op;
    logic [PC_WIDTH-1:0]         pc;
    logic [WORD_WIDTH-1:0]       imm;
    opnd_t                       rs1;
    opnd_t                       rs2;
    logic [TAG_W-1:0]            pdst;
  } entry_t;

  entry_t           ent_q [BR_IQ_DEPTH];
  entry_t           ent_d [BR_IQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                        issue_en_q;
  logic [DATA_WIDTH_BR_OP-1:0] op_q;
  logic [PC_WIDTH-1:0]         pc_q;
  logic [WORD_WIDTH-1:0]       imm_q;
  logic [WORD_WIDTH-1:0]       rs1_val_q;
  logic [WORD_WIDTH-1:0]       rs2_val_q;
  logic [TAG_W-1:0]            pdst_q;

  logic   full;
  logic   push;
  logic   pop;
  entry_t head_ent;
  opnd_t  head_rs1;
  opnd_t  head_rs2;
  entry_t new_ent;

  function automatic opnd_t wake(input opnd_t o, input logic v,
                                 input logic [TAG_W-1:0] rob,
                                 input logic [WORD_WIDTH-1:0] value);
    opnd_t r;
    r = o;
    if (!o.ready && v && (rob == o.rob)) begin
      r.ready = 1'b1;
      r.value = value;
    end
    return r;
  endfunction

  assign full     = (count_q == CNT_W'(BR_IQ_DEPTH));
  assign head_ent = ent_q[head_q];

`ifdef BR_IQ_CDB_BYPASS_EN
  assign head_rs1 = wake(head_ent.rs1, cdb_valid, cdb_rob, cdb_value);
  assign head_rs2 = wake(head_ent.rs2, cdb_valid, cdb_rob, cdb_value);
`else
  assign head_rs1 = head_ent.rs1;
  assign head_rs2 = head_ent.rs2;
`endif

  assign push = br_dispatch_en && !full && !br_flush;
  assign pop  = !br_flush && head_ent.valid && head_rs1.ready && head_rs2.ready;

  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.op    = br_dispatch_op;
    new_ent.pc    = br_dispatch_pc;
    new_ent.imm   = br_dispatch_imm;
    new_ent.pdst  = br_dispatch_Pdst;
    new_ent.rs1   = wake('{rob: br_dispatch_rs1_rob, ready: br_dispatch_rs1_ready,
                           value: br_dispatch_rs1_value}, cdb_valid, cdb_rob, cdb_value);
    new_ent.rs2   = wake('{rob: br_dispatch_rs2_rob, ready: br_dispatch_rs2_ready,
                           value: br_dispatch_rs2_value}, cdb_valid, cdb_rob, cdb_value);
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    for (int unsigned i = 0; i < BR_IQ_DEPTH; i++) begin
      if (ent_q[PTR_W'(i)].valid) begin
        ent_d[PTR_W'(i)].rs1 = wake(ent_q[PTR_W'(i)].rs1, cdb_valid, cdb_rob, cdb_value);
        ent_d[PTR_W'(i)].rs2 = wake(ent_q[PTR_W'(i)].rs2, cdb_valid, cdb_rob, cdb_value);
      end
    end

    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + 1'b1;
    end

    // tail never aliases a popping head: push into a full queue is refused above
    if (push) begin
      ent_d[tail_q] = new_ent;
      tail_d        = tail_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (br_flush) begin
      for (int unsigned i = 0; i < BR_IQ_DEPTH; i++) begin
        ent_d[PTR_W'(i)].valid = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BR_IQ_DEPTH; i++) begin
        ent_q[PTR_W'(i)] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_en_q <= 1'b0;
      op_q       <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      pdst_q     <= '0;
    end else begin
      issue_en_q <= pop;
      if (pop) begin
        op_q      <= head_ent.op;
        pc_q      <= head_ent.pc;
        imm_q     <= head_ent.imm;
        rs1_val_q <= head_rs1.value;
        rs2_val_q <= head_rs2.value;
        pdst_q    <= head_ent.pdst;
      end
    end
  end

  assign br_iq_full               = full;
  assign br_iq_count              = count_q;
  assign br_issue_en              = issue_en_q;
  assign br_issue_queue_op        = op_q;
  assign br_issue_queue_pc        = pc_q;
  assign br_issue_queue_imm       = imm_q;
  assign br_issue_queue_rs1_value = rs1_val_q;
  assign br_issue_queue_rs2_value = rs2_val_q;
  assign br_issue_queue_Pdst_out  = pdst_q;

endmodule

// File: tb/tb_br_issue_queue.sv
// Scoreboard bench for br_issue_queue: directed dispatch/wakeup/flush/reset vectors.
module tb_br_issue_queue;

`ifdef BR_IQ_CDB_BYPASS_EN
  localparam int WAKE_LAT = 1;
`else
  localparam int WAKE_LAT = 2;
`endif

  localparam logic [3:0] BEQ = 4'h0;
  localparam logic [3:0] BNE = 4'h1;
  localparam logic [3:0] BLT = 4'h4;
  localparam logic [3:0] BGE = 4'h5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_dispatch_en;
  logic [3:0]  br_dispatch_op;
  logic [31:0] br_dispatch_pc;
  logic [31:0] br_dispatch_imm;
  logic [3:0]  br_dispatch_rs1_rob;
  logic [3:0]  br_dispatch_rs2_rob;
  logic        br_dispatch_rs1_ready;
  logic        br_dispatch_rs2_ready;
  logic [31:0] br_dispatch_rs1_value;
  logic [31:0] br_dispatch_rs2_value;
  logic [3:0]  br_dispatch_Pdst;
  logic        cdb_valid;
  logic [3:0]  cdb_rob;
  logic [31:0] cdb_value;
  logic        br_flush;
  logic        br_iq_full;
  logic [2:0]  br_iq_count;
  logic        br_issue_en;
  logic [3:0]  br_issue_queue_op;
  logic [31:0] br_issue_queue_pc;
  logic [31:0] br_issue_queue_imm;
  logic [31:0] br_issue_queue_rs1_value;
  logic [31:0] br_issue_queue_rs2_value;
  logic [3:0]  br_issue_queue_Pdst_out;

  br_issue_queue #(
    .BR_IQ_DEPTH(4), .DATA_WIDTH_BR_OP(4), .PC_WIDTH(32), .WORD_WIDTH(32), .ROB_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .br_dispatch_en(br_dispatch_en), .br_dispatch_op(br_dispatch_op),
    .br_dispatch_pc(br_dispatch_pc), .br_dispatch_imm(br_dispatch_imm),
    .br_dispatch_rs1_rob(br_dispatch_rs1_rob), .br_dispatch_rs2_rob(br_dispatch_rs2_rob),
    .br_dispatch_rs1_ready(br_dispatch_rs1_ready), .br_dispatch_rs2_ready(br_dispatch_rs2_ready),
    .br_dispatch_rs1_value(br_dispatch_rs1_value), .br_dispatch_rs2_value(br_dispatch_rs2_value),
    .br_dispatch_Pdst(br_dispatch_Pdst),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .br_flush(br_flush), .br_iq_full(br_iq_full), .br_iq_count(br_iq_count),
    .br_issue_en(br_issue_en), .br_issue_queue_op(br_issue_queue_op),
    .br_issue_queue_pc(br_issue_queue_pc), .br_issue_queue_imm(br_issue_queue_imm),
    .br_issue_queue_rs1_value(br_issue_queue_rs1_value),
    .br_issue_queue_rs2_value(br_issue_queue_rs2_value),
    .br_issue_queue_Pdst_out(br_issue_queue_Pdst_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  pdst;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic [3:0] pdst, input int c);
    exp_t e;
    e.op = op; e.pc = pc; e.imm = imm; e.v1 = v1; e.v2 = v2; e.pdst = pdst; e.cyc = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && br_issue_en) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_issue: got pc=0x%0h op=%0h, expected no issue (cycle %0d)",
                 br_issue_queue_pc, br_issue_queue_op, cyc);
      end else begin
        e = sb.pop_front();
        chk("issue_cycle", 32'(cyc), 32'(e.cyc));
        chk("issue_op", 32'(br_issue_queue_op), 32'(e.op));
        chk("issue_pc", br_issue_queue_pc, e.pc);
        chk("issue_imm", br_issue_queue_imm, e.imm);
        chk("issue_rs1", br_issue_queue_rs1_value, e.v1);
        chk("issue_rs2", br_issue_queue_rs2_value, e.v2);
        chk("issue_pdst", 32'(br_issue_queue_Pdst_out), 32'(e.pdst));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_dispatch_en = 1'b0; br_dispatch_op = '0; br_dispatch_pc = '0; br_dispatch_imm = '0;
    br_dispatch_rs1_rob = '0; br_dispatch_rs2_rob = '0;
    br_dispatch_rs1_ready = 1'b0; br_dispatch_rs2_ready = 1'b0;
    br_dispatch_rs1_value = '0; br_dispatch_rs2_value = '0; br_dispatch_Pdst = '0;
    cdb_valid = 1'b0; cdb_rob = '0; cdb_value = '0; br_flush = 1'b0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [3:0] t1, input logic r1, input logic [31:0] v1,
                          input logic [3:0] t2, input logic r2, input logic [31:0] v2,
                          input logic [3:0] pd);
    br_dispatch_en = 1'b1; br_dispatch_op = op; br_dispatch_pc = pc; br_dispatch_imm = imm;
    br_dispatch_rs1_rob = t1; br_dispatch_rs1_ready = r1; br_dispatch_rs1_value = v1;
    br_dispatch_rs2_rob = t2; br_dispatch_rs2_ready = r2; br_dispatch_rs2_value = v2;
    br_dispatch_Pdst = pd;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_rob = tag; cdb_value = val;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  int w;

  initial begin : driver
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(br_iq_count), 32'd0);
    chk("reset_full", 32'(br_iq_full), 32'd0);
    chk("reset_en", 32'(br_issue_en), 32'd0);
    chk("reset_pc", br_issue_queue_pc, 32'd0);
    chk("reset_rs1", br_issue_queue_rs1_value, 32'd0);
    chk("reset_pdst", 32'(br_issue_queue_Pdst_out), 32'd0);
    rst_n = 1'b1;
    step();

    // Both operands ready: two-edge latency, single pulse.
    set_disp(BEQ, 32'h100, 32'h20, 4'd1, 1'b1, 32'd5, 4'd2, 1'b1, 32'd5, 4'd3);
    push_exp(BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 4'd3, cyc + 2);
    step(); idle();
    repeat (4) step();

    // rs1 woken by CDB three cycles after dispatch.
    set_disp(BNE, 32'h200, 32'h40, 4'd7, 1'b0, 32'd0, 4'd2, 1'b1, 32'h10, 4'd4);
    step(); idle();
    chk("t2_count", 32'(br_iq_count), 32'd1);
    step(); step();
    set_cdb(4'd7, 32'hAB);
    push_exp(BNE, 32'h200, 32'h40, 32'hAB, 32'h10, 4'd4, cyc + WAKE_LAT);
    step(); idle();
    repeat (4) step();
    chk("t2_drain", 32'(br_iq_count), 32'd0);

    // Fill with blocked head, drop the fifth, then drain in order across the wrap.
    for (int i = 0; i < 4; i++) begin
      set_disp(4'(i + 4), 32'h300 + 32'(4 * i), 32'(16 * i), 4'd9, (i != 0), 32'(i),
               4'd1, 1'b1, 32'h1000 + 32'(i), 4'(8 + i));
      step();
    end
    idle();
    chk("t3_full", 32'(br_iq_full), 32'd1);
    chk("t3_count", 32'(br_iq_count), 32'd4);
    set_disp(4'hF, 32'h310, 32'h0, 4'd1, 1'b1, 32'd1, 4'd1, 1'b1, 32'd1, 4'd15);
    step(); idle();
    chk("t3_drop_count", 32'(br_iq_count), 32'd4);
    chk("t3_drop_full", 32'(br_iq_full), 32'd1);
    set_cdb(4'd9, 32'h77);
    w = cyc + WAKE_LAT;
    push_exp(4'd4, 32'h300, 32'h00, 32'h77, 32'h1000, 4'd8, w);
    push_exp(4'd5, 32'h304, 32'h10, 32'd1, 32'h1001, 4'd9, w + 1);
    push_exp(4'd6, 32'h308, 32'h20, 32'd2, 32'h1002, 4'd10, w + 2);
    push_exp(4'd7, 32'h30C, 32'h30, 32'd3, 32'h1003, 4'd11, w + 3);
    step(); idle();
    repeat (6) step();
    chk("t3_empty_count", 32'(br_iq_count), 32'd0);
    chk("t3_empty_full", 32'(br_iq_full), 32'd0);

    // Younger ready entry waits behind a blocked head.
    set_disp(BGE, 32'h400, 32'h8, 4'd1, 1'b1, 32'h1, 4'd10, 1'b0, 32'd0, 4'd5);
    step();
    set_disp(BLT, 32'h404, 32'hC, 4'd1, 1'b1, 32'h2, 4'd2, 1'b1, 32'h3, 4'd6);
    step(); idle();
    repeat (3) step();
    chk("t4_count", 32'(br_iq_count), 32'd2);
    set_cdb(4'd10, 32'h55);
    w = cyc + WAKE_LAT;
    push_exp(BGE, 32'h400, 32'h8, 32'h1, 32'h55, 4'd5, w);
    push_exp(BLT, 32'h404, 32'hC, 32'h2, 32'h3, 4'd6, w + 1);
    step(); idle();
    repeat (4) step();

    // Capture at dispatch from a same-cycle broadcast, then dispatch while issuing.
    set_disp(BEQ, 32'h500, 32'h4, 4'd12, 1'b0, 32'd0, 4'd3, 1'b1, 32'h33, 4'd7);
    set_cdb(4'd12, 32'h99);
    push_exp(BEQ, 32'h500, 32'h4, 32'h99, 32'h33, 4'd7, cyc + 2);
    step(); idle();
    chk("t5_count1", 32'(br_iq_count), 32'd1);
    set_disp(BNE, 32'h504, 32'h4, 4'd1, 1'b1, 32'h1, 4'd2, 1'b1, 32'h2, 4'd1);
    push_exp(BNE, 32'h504, 32'h4, 32'h1, 32'h2, 4'd1, cyc + 2);
    step(); idle();
    chk("t5_count_swap", 32'(br_iq_count), 32'd1);
    step();
    chk("t5_count0", 32'(br_iq_count), 32'd0);
    repeat (2) step();

    // Flush with three queued and one dispatching.
    for (int i = 0; i < 3; i++) begin
      set_disp(BLT, 32'h600 + 32'(4 * i), 32'h0, 4'd14, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'(i));
      step();
    end
    set_disp(BLT, 32'h60C, 32'h0, 4'd1, 1'b1, 32'd1, 4'd2, 1'b1, 32'd2, 4'd3);
    br_flush = 1'b1;
    step(); idle();
    chk("t6_count", 32'(br_iq_count), 32'd0);
    chk("t6_full", 32'(br_iq_full), 32'd0);
    chk("t6_en", 32'(br_issue_en), 32'd0);
    set_cdb(4'd14, 32'hEE);
    step(); idle();
    repeat (4) step();
    chk("t6_count_after", 32'(br_iq_count), 32'd0);

    // Asynchronous reset while an issue pulse is on the outputs.
    set_disp(BEQ, 32'h700, 32'h8, 4'd1, 1'b1, 32'h7, 4'd2, 1'b1, 32'h7, 4'd2);
    push_exp(BEQ, 32'h700, 32'h8, 32'h7, 32'h7, 4'd2, cyc + 2);
    step();
    set_disp(BNE, 32'h704, 32'h8, 4'd15, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd9);
    step(); idle();
    chk("t7_en_before", 32'(br_issue_en), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_en_async", 32'(br_issue_en), 32'd0);
    chk("t7_pc_async", br_issue_queue_pc, 32'd0);
    chk("t7_rs1_async", br_issue_queue_rs1_value, 32'd0);
    chk("t7_pdst_async", 32'(br_issue_queue_Pdst_out), 32'd0);
    chk("t7_count_async", 32'(br_iq_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    set_cdb(4'd15, 32'h44);
    step(); idle();
    repeat (4) step();
    chk("t7_count_after", 32'(br_iq_count), 32'd0);
    chk("t7_en_after", 32'(br_issue_en), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
